// File: rtl/cache_pkg.sv
// cache_pkg: shared types and block geometry for the cache miss handler.
// Block = 8 words of 16 bits, so 3 offset bits and 4 byte-offset bits.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS = 3;
  localparam int BLOCK_BYTE_BITS = 4;

  typedef logic [1:0] fill_state_t;

  localparam fill_state_t IDLE = 2'd0;
  localparam fill_state_t FILL = 2'd1;
  localparam fill_state_t TAG = 2'd2;

endpackage

// File: rtl/cache_fill_counter.sv
// cache_fill_counter: word counter for one block, saturates at
// WORDS_PER_BLOCK so the MSB doubles as a "block done" flag.
module cache_fill_counter
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [OFFSET_BITS:0] count
);

  localparam int CW = OFFSET_BITS + 1;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (inc && !count[OFFSET_BITS]) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss handler, streams one block from memory.
// Define CACHE_FILL_PERF_EN to add miss_count / fill_cycles outputs.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_detected,
  input  logic [ADDR_WIDTH-1:0]  miss_address,
  input  logic                   memory_data_valid,
  input  logic [DATA_WIDTH-1:0]  memory_data,
  output logic                   fsm_busy,
  output logic                   mem_read_en,
  output logic [ADDR_WIDTH-1:0]  memory_address,
  output logic                   write_data_array,
  output logic [DATA_WIDTH-1:0]  fill_data,
  output logic [OFFSET_BITS-1:0] offset_write,
  output logic                   write_tag_array,
`ifdef CACHE_FILL_PERF_EN
  output logic [15:0]            miss_count,
  output logic [15:0]            fill_cycles,
`endif
  output logic                   valid_bit
);

  localparam int CW = OFFSET_BITS + 1;

  fill_state_t state;
  fill_state_t next_state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] rx_cnt;
  logic idle, in_fill, in_tag;
  logic start, rd, wr, last;
  logic [BLOCK_BYTE_BITS-1:0] unused_low;

  assign unused_low = miss_address[BLOCK_BYTE_BITS-1:0];

  assign idle = state == IDLE;
  assign in_fill = state == FILL;
  assign in_tag = state == TAG;

  assign start = rst && idle && miss_detected;
  assign rd = rst && in_fill && !issue_cnt[OFFSET_BITS];
  // A word before any read was issued cannot be ours
  assign wr = rst && in_fill && memory_data_valid
    && (issue_cnt != '0);
  assign last = wr && (rx_cnt == CW'(WORDS_PER_BLOCK - 1));

  always_comb begin
    next_state = state;
    unique case (1'b1)
      idle:    if (miss_detected) next_state = FILL;
      in_fill: if (last) next_state = TAG;
      in_tag:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      base <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        base <= {miss_address[ADDR_WIDTH-1:BLOCK_BYTE_BITS],
                 {BLOCK_BYTE_BITS{1'b0}}};
      end
    end
  end

  cache_fill_counter u_issue (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (rd),
    .count (issue_cnt)
  );

  cache_fill_counter u_rx (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (wr),
    .count (rx_cnt)
  );

  // Stall the miss cycle itself, before the state register moves
  assign fsm_busy = (!rst || idle) ? miss_detected : 1'b1;
  assign mem_read_en = rd;
  assign memory_address = rd
    ? (base | ADDR_WIDTH'({issue_cnt[OFFSET_BITS-1:0], 1'b0}))
    : '0;
  assign write_data_array = wr;
  assign fill_data = memory_data;
  assign offset_write = wr ? rx_cnt[OFFSET_BITS-1:0] : '0;
  assign write_tag_array = rst && in_tag;
  assign valid_bit = rst && in_tag;

`ifdef CACHE_FILL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      miss_count <= '0;
      fill_cycles <= '0;
    end else begin
      if (start) miss_count <= miss_count + 16'd1;
      if (in_fill || in_tag) fill_cycles <= fill_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed bench for the cache miss handler with
// a latency-L memory model; define CACHE_FILL_PERF_EN for counter checks.
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic fsm_busy, mem_read_en, write_data_array;
  logic write_tag_array, valid_bit;
  logic [15:0] memory_address, fill_data;
  logic [2:0] offset_write;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] miss_count, fill_cycles;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 4;
  bit gap_mode = 1'b0;

  typedef struct {
    logic [15:0] addr;
    int due;
  } req_t;
  req_t pend[$];

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_data         (fill_data),
    .offset_write      (offset_write),
    .write_tag_array   (write_tag_array),
`ifdef CACHE_FILL_PERF_EN
    .miss_count        (miss_count),
    .fill_cycles       (fill_cycles),
`endif
    .valid_bit         (valid_bit)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory: in-order replies L cycles after each read, optional gaps
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    memory_data_valid = 1'b0;
    memory_data = '0;
    if (pend.size() > 0 && pend[0].due <= cyc
        && !(gap_mode && cyc[0])) begin
      memory_data_valid = 1'b1;
      memory_data = word_of(pend[0].addr);
      void'(pend.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) pend.delete();
    else if (mem_read_en) pend.push_back('{memory_address, cyc + lat});
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    logic [4:0] got_v;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got_v = {fsm_busy, mem_read_en, write_data_array,
             write_tag_array, valid_bit};
    checks++;
    if (got_v !== 5'b0 || memory_address !== 16'h0
        || offset_write !== 3'd0) begin
      errors++;
      $display("FAIL reset_low ctl=%b addr=%h off=%0d need 0",
               got_v, memory_address, offset_write);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    got_v = {fsm_busy, mem_read_en, write_data_array,
             write_tag_array, valid_bit};
    checks++;
    if (got_v !== 5'b0 || memory_address !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle ctl=%b addr=%h need 0",
               got_v, memory_address);
    end
    idle_cycles(1);
  endtask

  task automatic test_basic;
    logic [4:0] exp_v, got_v;
    logic [15:0] b;
    b = 16'h1230;
    lat = 4;
    miss_detected = 1'b1;
    miss_address = 16'h1236;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      exp_v = {k <= 13, k >= 1 && k <= 8, k >= 5 && k <= 12,
               k == 13, k == 13};
      got_v = {fsm_busy, mem_read_en, write_data_array,
               write_tag_array, valid_bit};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL basic_ctl k=%0d got=%b need=%b", k, got_v, exp_v);
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (memory_address !== b + 16'(2 * (k - 1))) begin
          errors++;
          $display("FAIL basic_addr k=%0d got=%h need=%h", k,
                   memory_address, b + 16'(2 * (k - 1)));
        end
      end
      if (k >= 5 && k <= 12) begin
        checks++;
        if (offset_write !== 3'(k - 5)
            || fill_data !== word_of(b + 16'(2 * (k - 5)))) begin
          errors++;
          $display("FAIL basic_wr k=%0d off=%0d data=%h need %0d/%h",
                   k, offset_write, fill_data, k - 5,
                   word_of(b + 16'(2 * (k - 5))));
        end
      end
      @(posedge clk); #2;
      if (k == 0) miss_detected = 1'b0;
    end
  endtask

  task automatic test_gaps;
    int nw;
    int tag_k;
    logic [15:0] b;
    b = 16'h4A50;
    nw = 0;
    tag_k = -1;
    gap_mode = 1'b1;
    miss_detected = 1'b1;
    miss_address = 16'h4A5E;
    for (int k = 0; k <= 40 && tag_k < 0; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        checks++;
        if (write_data_array !== memory_data_valid) begin
          errors++;
          $display("FAIL gaps_wde k=%0d got=%b need=%b", k,
                   write_data_array, memory_data_valid);
        end
      end
      if (write_data_array === 1'b1) begin
        checks++;
        if (offset_write !== 3'(nw)
            || fill_data !== word_of(b + 16'(2 * nw))) begin
          errors++;
          $display("FAIL gaps_wr n=%0d off=%0d data=%h", nw,
                   offset_write, fill_data);
        end
        nw++;
      end
      if (write_tag_array === 1'b1) begin
        tag_k = k;
        checks++;
        if (nw !== 8 || valid_bit !== 1'b1) begin
          errors++;
          $display("FAIL gaps_tag words=%0d valid=%b need 8/1",
                   nw, valid_bit);
        end
      end
      @(posedge clk); #2;
      if (k == 0) miss_detected = 1'b0;
    end
    checks++;
    if (tag_k < 0) begin
      errors++;
      $display("FAIL gaps_timeout words=%0d need tag", nw);
    end
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL gaps_release busy=%b need 0", fsm_busy);
    end
    gap_mode = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_miss_held;
    int nr;
    int ntag;
    nr = 0;
    ntag = 0;
    lat = 4;
    miss_detected = 1'b1;
    miss_address = 16'h1236;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (mem_read_en === 1'b1) begin
        checks++;
        if (memory_address !== 16'h1230 + 16'(2 * nr)) begin
          errors++;
          $display("FAIL held_addr n=%0d got=%h need=%h", nr,
                   memory_address, 16'h1230 + 16'(2 * nr));
        end
        nr++;
      end
      if (write_tag_array === 1'b1) ntag++;
      @(posedge clk); #2;
      if (k == 0) miss_address = 16'hABC0;
    end
    miss_detected = 1'b0;
    @(negedge clk);
    checks++;
    if (nr !== 8 || ntag !== 1 || fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_single reads=%0d tags=%0d busy=%b need 8/1/0",
               nr, ntag, fsm_busy);
    end
    idle_cycles(1);
  endtask

  task automatic test_reset_mid;
    logic [4:0] got_v;
    int ntag;
    ntag = 0;
    lat = 4;
    miss_detected = 1'b1;
    miss_address = 16'h2200;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      got_v = {fsm_busy, mem_read_en, write_data_array,
               write_tag_array, valid_bit};
      if (k >= 6) begin
        checks++;
        if (got_v !== 5'b0 || memory_address !== 16'h0
            || offset_write !== 3'd0) begin
          errors++;
          $display("FAIL rstmid k=%0d ctl=%b addr=%h need 0", k,
                   got_v, memory_address);
        end
      end
      if (write_tag_array === 1'b1) ntag++;
      @(posedge clk); #2;
      if (k == 0) miss_detected = 1'b0;
      if (k == 5) rst = 1'b0;
      if (k == 6) rst = 1'b1;
    end
    checks++;
    if (ntag !== 0) begin
      errors++;
      $display("FAIL rstmid_tag pulses=%0d need 0", ntag);
    end
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_v, got_v;
    logic [15:0] b;
    int kk;
    lat = 4;
    miss_detected = 1'b1;
    miss_address = 16'h0010;
    for (int k = 0; k <= 28; k++) begin
      kk = (k < 14) ? k : k - 14;
      b = (k < 14) ? 16'h0010 : 16'h8000;
      @(negedge clk);
      exp_v = {kk <= 13, kk >= 1 && kk <= 8, kk >= 5 && kk <= 12,
               kk == 13, kk == 13};
      got_v = {fsm_busy, mem_read_en, write_data_array,
               write_tag_array, valid_bit};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_ctl k=%0d got=%b need=%b", k, got_v, exp_v);
      end
      if (kk >= 1 && kk <= 8) begin
        checks++;
        if (memory_address !== b + 16'(2 * (kk - 1))) begin
          errors++;
          $display("FAIL b2b_addr k=%0d got=%h need=%h", k,
                   memory_address, b + 16'(2 * (kk - 1)));
        end
      end
      if (kk >= 5 && kk <= 12) begin
        checks++;
        if (offset_write !== 3'(kk - 5)
            || fill_data !== word_of(b + 16'(2 * (kk - 5)))) begin
          errors++;
          $display("FAIL b2b_wr k=%0d off=%0d data=%h", k,
                   offset_write, fill_data);
        end
      end
      @(posedge clk); #2;
      if (k == 0 || k == 14) miss_detected = 1'b0;
      if (k == 13) begin
        miss_detected = 1'b1;
        miss_address = 16'h8000;
      end
    end
  endtask

`ifdef CACHE_FILL_PERF_EN
  task automatic test_perf;
    rst = 1'b0;
    idle_cycles(2);
    rst = 1'b1;
    lat = 4;
    for (int f = 0; f < 3; f++) begin
      @(posedge clk); #2;
      miss_detected = 1'b1;
      miss_address = 16'(16'h0100 * (f + 1));
      @(posedge clk); #2;
      miss_detected = 1'b0;
      repeat (14) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (miss_count !== 16'd3 || fill_cycles !== 16'd39) begin
      errors++;
      $display("FAIL perf miss=%0d cycles=%0d need 3/39",
               miss_count, fill_cycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    idle_cycles(2);
    test_gaps();
    test_miss_held();
    test_reset_mid();
    idle_cycles(2);
    test_back_to_back();
    idle_cycles(2);
`ifdef CACHE_FILL_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
